flick_debouncer: RTL and testbench

//  Conditions the raw mechanical flick push-button before it reaches the bound flasher.
//  - Synchronises the async pin into clk and rejects contact bounce.
//  - Drives the clean level into the flasher's flick input.
//  - Also emits single-cycle press/release strobes, a long-press strobe and a bounce-event counter.

---
 rtl/flick_debouncer_pkg.sv | 20 ++
 rtl/flick_debouncer_sync_chain.sv | 22 ++
 rtl/flick_debouncer.sv | 130 +++++++++++++
 tb/tb_flick_debouncer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/flick_debouncer_pkg.sv
// Shared FSM encoding and helpers for the flick push-button debouncer.
// Latency: none (types and functions only). Backpressure: not applicable.
// Imported by the debouncer top level.
package flick_debouncer_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  localparam logic [7:0] BOUNCE_MAX = 8'hFF;

  // Bounce counter sticks at its ceiling so heavy chatter never reads as low activity.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == BOUNCE_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/flick_debouncer_sync_chain.sv
// Multi-flop synchroniser bringing the asynchronous button pin into clk.
// Latency: STAGES cycles. Backpressure: none, samples every cycle.
// Cleared asynchronously to 0 by the active-low reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/flick_debouncer.sv
// Debounces the flick button: clean level, press/release/long-press strobes, bounce counter.
// Latency: level and strobe appear SYNC_STAGES+DB_CYCLES edges after a clean pin change.
// Backpressure: none; strobes are single-cycle and cannot be stalled.
module flick_debouncer
  import flick_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 500000,
  parameter int LONG_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flick_raw,
  output logic       flick_level,
  output logic       flick_rise,
  output logic       flick_fall,
  output logic       long_press,
  output logic [7:0] bounce_cnt
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);

  logic             s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             long_q, long_d;
  logic [7:0]       bcnt_q, bcnt_d;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (flick_raw),
    .q     (s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOW;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    long_d  = 1'b0;
    bcnt_d  = bcnt_q;

    // Hold time keeps running through a release check, so a bounce back to
    // S_HIGH finds the counter already saturated and cannot fire long_press twice.
    if (state_q == S_HIGH || state_q == S_FALL_CHK) begin
      if (hcnt_q != LONG_MAX) hcnt_d = hcnt_q + 1'b1;
      if (hcnt_q == LONG_LAST) long_d = 1'b1;
    end

    case (state_q)
      S_LOW: begin
        if (s) begin
          state_d = S_RISE_CHK;
          dcnt_d  = CNT_W'(1);
        end
      end
      S_RISE_CHK: begin
        if (!s) begin
          state_d = S_LOW;
          bcnt_d  = sat_inc8(bcnt_q);
        end else if (dcnt_q == DB_LAST) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          hcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_d = S_FALL_CHK;
          dcnt_d  = CNT_W'(1);
        end
      end
      S_FALL_CHK: begin
        if (s) begin
          state_d = S_HIGH;
          bcnt_d  = sat_inc8(bcnt_q);
        end else if (dcnt_q == DB_LAST) begin
          state_d = S_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  assign flick_level = level_q;
  assign flick_rise  = rise_q;
  assign flick_fall  = fall_q;
  assign long_press  = long_q;
  assign bounce_cnt  = bcnt_q;

endmodule

// File: tb/tb_flick_debouncer.sv
// Directed bench for flick_debouncer with SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=16.
module tb_flick_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic       flick_raw;
  logic       flick_level, flick_rise, flick_fall, long_press;
  logic [7:0] bounce_cnt;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  typedef struct {
    logic       raw;
    logic       lvl;
    logic       rise;
    logic       fall;
    logic       lng;
    logic [7:0] bcnt;
  } vec_t;

  vec_t tbl[$];

  flick_debouncer #(
    .SYNC_STAGES (2),
    .DB_CYCLES   (4),
    .LONG_CYCLES (16),
    .CNT_W       (26)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flick_raw   (flick_raw),
    .flick_level (flick_level),
    .flick_rise  (flick_rise),
    .flick_fall  (flick_fall),
    .long_press  (long_press),
    .bounce_cnt  (bounce_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (flick_rise && flick_fall)  viol++;
      if (flick_rise && !flick_level) viol++;
      if (flick_fall && flick_level)  viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive raw before the next rising edge, then sample on the following falling edge.
  task automatic tick(input logic r);
    flick_raw = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic l, input logic ri, input logic f,
                     input logic lp, input logic [7:0] b);
    vec_t v;
    v.raw = r; v.lvl = l; v.rise = ri; v.fall = f; v.lng = lp; v.bcnt = b;
    tbl.push_back(v);
  endtask

  initial begin
    int rise_e, long_e, fall_e, long_n, lvl_low;

    // raw, level, rise, fall, long, bounce_cnt after each edge
    // clean press: level and rise at edge 6
    add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(1,0,0,0,0,0);
    add(1,0,0,0,0,0); add(1,1,1,0,0,0); add(1,1,0,0,0,0); add(1,1,0,0,0,0);
    // clean release: fall at edge 6
    add(0,1,0,0,0,0); add(0,1,0,0,0,0); add(0,1,0,0,0,0); add(0,1,0,0,0,0);
    add(0,1,0,0,0,0); add(0,0,0,1,0,0); add(0,0,0,0,0,0);
    // two aborted presses
    add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(0,0,0,0,0,0); add(1,0,0,0,0,0);
    add(1,0,0,0,0,1); add(0,0,0,0,0,1); add(0,0,0,0,0,1); add(0,0,0,0,0,2);
    add(0,0,0,0,0,2); add(0,0,0,0,0,2);

    // reset with pin low
    reset = 1'b0;
    flick_raw = 1'b0;
    #1;
    chk("async_reset_level", flick_level, 0);
    for (int i = 0; i < 10; i++) tick(0);
    chk("reset_level", flick_level, 0);
    chk("reset_rise", flick_rise, 0);
    chk("reset_fall", flick_fall, 0);
    chk("reset_long", long_press, 0);
    chk("reset_bcnt", bounce_cnt, 0);
    reset = 1'b1;
    tick(0);

    foreach (tbl[i]) begin
      tick(tbl[i].raw);
      chk($sformatf("vec%0d", i),
          {flick_level, flick_rise, flick_fall, long_press, bounce_cnt},
          {tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].lng, tbl[i].bcnt});
    end

    // long press: fires once, 16 cycles after the rise strobe
    rise_e = 0; long_e = 0; long_n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (flick_rise) rise_e = i;
      if (long_press) begin long_e = i; long_n++; end
    end
    chk("lp_rise_edge", rise_e, 6);
    chk("lp_long_delay", long_e - rise_e, 16);
    chk("lp_long_count", long_n, 1);
    fall_e = 0;
    for (int i = 1; i <= 20 && fall_e == 0; i++) begin
      tick(0);
      if (flick_fall) fall_e = i;
    end
    chk("lp_fall_edge", fall_e, 6);

    // release glitch while pressed: no level change, one bounce, no second long press
    long_n = 0; lvl_low = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (long_press) long_n++;
    end
    chk("gl_level_before", flick_level, 1);
    tick(0); if (!flick_level) lvl_low++;
    tick(0); if (!flick_level) lvl_low++;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (long_press) long_n++;
      if (!flick_level) lvl_low++;
    end
    chk("gl_level_drops", lvl_low, 0);
    chk("gl_bcnt", bounce_cnt, 3);
    chk("gl_long_count", long_n, 1);
    fall_e = 0;
    for (int i = 1; i <= 20 && fall_e == 0; i++) begin
      tick(0);
      if (flick_fall) fall_e = i;
    end
    chk("gl_fall_edge", fall_e, 6);

    // reset in the middle of rise debounce, pin still held
    for (int i = 0; i < 4; i++) tick(1);
    #2 reset = 1'b0;
    #1;
    chk("mid_reset_bcnt", bounce_cnt, 0);
    chk("mid_reset_level", flick_level, 0);
    chk("mid_reset_rise", flick_rise, 0);
    tick(1);
    tick(1);
    chk("mid_reset_hold_level", flick_level, 0);
    reset = 1'b1;
    rise_e = 0;
    for (int i = 1; i <= 20 && rise_e == 0; i++) begin
      tick(1);
      if (flick_rise) rise_e = i;
    end
    chk("rr_rise_edge", rise_e, 6);
    fall_e = 0;
    for (int i = 1; i <= 20 && fall_e == 0; i++) begin
      tick(0);
      if (flick_fall) fall_e = i;
    end
    chk("rr_fall_edge", fall_e, 6);

    // sustained chatter: bounce counter saturates, level never moves
    lvl_low = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1); if (flick_level) lvl_low++;
      tick(0); if (flick_level) lvl_low++;
    end
    for (int i = 0; i < 4; i++) tick(0);
    chk("sat_bcnt", bounce_cnt, 8'hFF);
    chk("sat_level_highs", lvl_low, 0);

    chk("strobe_invariants", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
